matrix_stream_loader: RTL and testbench



---
 rtl/matrix_stream_loader_pkg.sv | 27 ++
 rtl/matrix_stream_loader.sv | 131 +++++++++++++
 tb/tb_matrix_stream_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// Shared definitions for the matrix stream loader.
//   state_e         : loader FSM states (LOAD collects samples, FULL presents the matrix)
//   count_width()   : width of a counter that spans 0..size_a*size_b inclusive
//   index_width()   : width of a row/column index, never narrower than one bit
//   elem_t          : matrix element type at the default sample width
package matrix_stream_loader_pkg;

  localparam int DEFAULT_SIZE_A = 8;
  localparam int DEFAULT_SIZE_B = 8;
  localparam int DEFAULT_N_BITS = 22;

  typedef logic [DEFAULT_N_BITS-1:0] elem_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_e;

  function automatic int count_width(input int size_a, input int size_b);
    return $clog2(size_a * size_b + 1);
  endfunction

  function automatic int index_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Collects a serial stream of samples into a SIZE_A x SIZE_B matrix buffer and
// presents it, complete and stable, to a downstream combinational stage.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset; clears state and the whole buffer
//   flush       synchronous abort of the current fill (buffer contents kept)
//   in_data     sample value
//   in_valid    source offers a sample
//   in_ready    loader accepts a sample this cycle (LOAD state)
//   out_matrix  buffered matrix, unpacked [row][col]
//   out_valid   out_matrix is complete and stable (FULL state)
//   out_ack     consumer has taken the matrix; releases the buffer
//   fill_count  number of elements accepted in the current fill
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int SIZE_A    = DEFAULT_SIZE_A,
  parameter int SIZE_B    = DEFAULT_SIZE_B,
  parameter int N_BITS    = DEFAULT_N_BITS,
  parameter int ROW_MAJOR = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [N_BITS-1:0]                     in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [N_BITS-1:0]                     out_matrix [SIZE_A][SIZE_B],
  output logic                                  out_valid,
  input  logic                                  out_ack,
  output logic [count_width(SIZE_A, SIZE_B)-1:0] fill_count
);

  localparam int N_ELEM = SIZE_A * SIZE_B;
  localparam int CNT_W  = count_width(SIZE_A, SIZE_B);
  localparam int ROW_W  = index_width(SIZE_A);
  localparam int COL_W  = index_width(SIZE_B);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } idx_t;

  state_e state;
  state_e state_next;
  idx_t   idx;
  logic   accept;
  logic   last;

  // Walks the fill order. The outer index never needs to wrap here: the final
  // accept of a fill forces the indices back to zero instead.
  function automatic idx_t next_idx(input idx_t cur);
    idx_t nxt;
    nxt = cur;
    if (ROW_MAJOR != 0) begin
      if (cur.col == COL_W'(SIZE_B - 1)) begin
        nxt.col = '0;
        nxt.row = cur.row + ROW_W'(1);
      end else begin
        nxt.col = cur.col + COL_W'(1);
      end
    end else begin
      if (cur.row == ROW_W'(SIZE_A - 1)) begin
        nxt.row = '0;
        nxt.col = cur.col + COL_W'(1);
      end else begin
        nxt.row = cur.row + ROW_W'(1);
      end
    end
    return nxt;
  endfunction

  // Handshake outputs decode the state register only.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == FULL);

  assign last = (fill_count == CNT_W'(N_ELEM - 1));

  always_comb begin
    // NOTE: defaults are assigned first so every path drives these signals and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      LOAD: begin
        accept = in_valid;
        if (in_valid && last) state_next = FULL;
      end
      FULL: begin
        if (out_ack) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
    // Flush outranks both the ack and a sample arriving in the same cycle.
    if (flush) begin
      state_next = LOAD;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      idx        <= '0;
      fill_count <= '0;
      // NOTE: the buffer is cleared on reset so a consumer never sees stale data from before reset;
      // flush deliberately does not touch it.
      for (int a = 0; a < SIZE_A; a++) begin
        for (int b = 0; b < SIZE_B; b++) begin
          out_matrix[a][b] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state <= state_next;
      if (flush || (state == FULL && out_ack)) begin
        idx        <= '0;
        fill_count <= '0;
      end else if (accept) begin
        out_matrix[idx.row][idx.col] <= in_data;
        fill_count                   <= fill_count + CNT_W'(1);
        if (last) begin
          idx <= '0;
        end else begin
          idx <= next_idx(idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader. Three configurations run side by
// side: 2x3 row-major, 2x3 column-major and the 8x8 default. Each one has its
// own stimulus process, a reference model that places the k-th accepted sample
// by plain arithmetic, a scoreboard queue of completed matrices, and a monitor
// that compares the DUT against the model on every falling edge.
module tb_matrix_stream_loader;
  import matrix_stream_loader_pkg::*;

  localparam int NB = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int SA = (g == 2) ? 8 : 2;
    localparam int SB = (g == 2) ? 8 : 3;
    localparam int RM = (g == 1) ? 0 : 1;
    localparam int N  = SA * SB;
    localparam int CW = count_width(SA, SB);
    localparam int RAND_CYCLES = 200 + 8 * N;

    typedef logic [N*NB-1:0] flat_t;

    logic          rst_n;
    logic          flush;
    logic [NB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] out_matrix [SA][SB];
    logic          out_valid;
    logic          out_ack;
    logic [CW-1:0] fill_count;

    matrix_stream_loader #(
      .SIZE_A    (SA),
      .SIZE_B    (SB),
      .N_BITS    (NB),
      .ROW_MAJOR (RM)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_matrix (out_matrix),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .fill_count (fill_count)
    );

    // Reference model: matrix contents, samples taken this fill, and whether a
    // complete matrix is being presented.
    logic [NB-1:0] m_mat [SA][SB];
    int            m_cnt = 0;
    bit            m_full = 1'b0;
    flat_t         exp_q [$];
    bit            armed = 1'b0;
    bit            prev_valid = 1'b0;
    bit            done_blk = 1'b0;

    function automatic flat_t flat_model();
      flat_t f;
      f = '0;
      for (int i = 0; i < SA; i++)
        for (int j = 0; j < SB; j++)
          f[(i*SB + j)*NB +: NB] = m_mat[i][j];
      return f;
    endfunction

    function automatic flat_t flat_dut();
      flat_t f;
      f = '0;
      for (int i = 0; i < SA; i++)
        for (int j = 0; j < SB; j++)
          f[(i*SB + j)*NB +: NB] = out_matrix[i][j];
      return f;
    endfunction

    // Reports the first differing element (or element [0][0] when all agree).
    task automatic check_flat(input string nm, input flat_t act, input flat_t exp);
      int k;
      k = 0;
      for (int e = N - 1; e >= 0; e--)
        if (act[e*NB +: NB] !== exp[e*NB +: NB]) k = e;
      check($sformatf("c%0d_%s[%0d][%0d]", g, nm, k / SB, k % SB),
            64'(act[k*NB +: NB]), 64'(exp[k*NB +: NB]));
    endtask

    int r_pos, c_pos;
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < SA; i++)
          for (int j = 0; j < SB; j++)
            m_mat[i][j] = '0;
        m_cnt  = 0;
        m_full = 1'b0;
      end else if (flush) begin
        m_cnt  = 0;
        m_full = 1'b0;
      end else if (m_full) begin
        if (out_ack) begin
          m_cnt  = 0;
          m_full = 1'b0;
        end
      end else if (in_valid) begin
        r_pos = (RM != 0) ? m_cnt / SB : m_cnt % SA;
        c_pos = (RM != 0) ? m_cnt % SB : m_cnt / SA;
        m_mat[r_pos][c_pos] = in_data;
        m_cnt++;
        if (m_cnt == N) begin
          m_full = 1'b1;
          exp_q.push_back(flat_model());
        end
      end
    end

    always @(negedge clk) begin
      if (armed && !done_blk) begin
        check($sformatf("c%0d_in_ready", g), 64'(in_ready), 64'(!m_full));
        check($sformatf("c%0d_out_valid", g), 64'(out_valid), 64'(m_full));
        check($sformatf("c%0d_fill_count", g), 64'(fill_count), 64'(m_cnt));
        check_flat("matrix", flat_dut(), flat_model());
        if (out_valid && !prev_valid) begin
          check($sformatf("c%0d_sb_has_entry", g), 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check_flat("sb_matrix", flat_dut(), exp_q.pop_front());
        end
        prev_valid = out_valid;
      end
    end

    task automatic drive(input bit v, input logic [NB-1:0] d, input bit f, input bit a, input bit r);
      in_valid = v;
      in_data  = d;
      flush    = f;
      out_ack  = a;
      rst_n    = r;
      @(negedge clk);
    endtask

    initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      out_ack  = 1'b0;
      @(negedge clk);
      drive(0, '0, 0, 0, 0);
      drive(0, '0, 0, 0, 0);
      armed = 1'b1;

      // Held-valid fill with 1..N, then backpressure while FULL.
      for (int k = 1; k <= N; k++) drive(1, NB'(k), 0, 0, 1);
      repeat (10) drive(1, 22'h3FFFFF, 0, 0, 1);
      drive(0, '0, 0, 1, 1);
      drive(1, NB'(7), 0, 0, 1);

      // Gapped source after a flush: valid pattern 1,0,0 with junk data in the gaps.
      drive(0, '0, 1, 0, 1);
      for (int k = 0; k < N; k++) begin
        drive(1, NB'(100 + k), 0, 0, 1);
        drive(0, NB'($urandom), 0, 0, 1);
        drive(0, NB'($urandom), 0, 0, 1);
      end
      drive(0, '0, 0, 1, 1);

      // Flush after four samples, with a sample offered in the flush cycle.
      for (int k = 1; k <= 4; k++) drive(1, NB'(k), 0, 0, 1);
      drive(1, NB'(22'h155), 1, 0, 1);
      for (int k = 10; k < 10 + N; k++) drive(1, NB'(k), 0, 0, 1);
      drive(0, '0, 0, 1, 1);

      // Reset mid-fill together with flush and a sample.
      for (int k = 1; k <= 3; k++) drive(1, NB'(200 + k), 0, 0, 1);
      drive(1, NB'(99), 1, 0, 0);

      // Fill to FULL, then reset together with ack and flush.
      for (int k = 1; k <= N; k++) drive(1, NB'(300 + k), 0, 0, 1);
      drive(1, NB'(5), 1, 1, 0);

      // Randomised traffic.
      repeat (RAND_CYCLES)
        drive($urandom_range(0, 1) == 1, NB'($urandom), $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 149) != 0);

      drive(0, '0, 0, 0, 1);
      drive(0, '0, 0, 0, 1);
      check($sformatf("c%0d_sb_drained", g), 64'(exp_q.size()), 64'd0);
      done_blk = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 30000; c++) begin
      if (cfg[0].done_blk && cfg[1].done_blk && cfg[2].done_blk) break;
      @(posedge clk);
    end
    check("all_configs_finished",
          64'(cfg[0].done_blk && cfg[1].done_blk && cfg[2].done_blk), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
